gf3m_digit_serial_mult: RTL and testbench

- Parametrised digit-serial multiplier over GF(3^M), reduction polynomial f(x) = x^M + x^K + 2.
- Processes D trits of operand b per cycle, most significant digit first.
- Generalises the fixed M=97, 194-bit field multiplier used by the pairing datapath; the pairing controller drives it through start/done.
- Default parameters (M=97, K=12, D=4) drop in for the existing 194-bit datapath.

---
 rtl/gf3m_digit_serial_mult_pkg.sv | 57 +++++
 rtl/gf3m_digit_step.sv | 47 ++++
 rtl/gf3m_digit_serial_mult.sv | 135 +++++++++++++
 tb/tb_gf3m_digit_serial_mult.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf3m_digit_serial_mult_pkg.sv
// -----------------------------------------------------------------------------
// gf3m_digit_serial_mult_pkg
// Shared definitions for the GF(3^M) digit-serial multiplier:
//   - trit encodings TRIT_0/TRIT_1/TRIT_2 (2 bits per trit, 2'b11 never produced)
//   - FSM state encoding (IDLE/RUN/FINISH)
//   - default field parameters M/K/D (M=97, K=12, D=4)
//   - elem_msb(m): MSB index of a 2*m-bit field element (the W(M) helper)
//   - trit_add/trit_mul: mod-3 coefficient arithmetic on encoded trits
// No ports (package).
// -----------------------------------------------------------------------------
package gf3m_digit_serial_mult_pkg;

  localparam int M_DEF = 97;
  localparam int K_DEF = 12;
  localparam int D_DEF = 4;

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b01;
  localparam logic [1:0] TRIT_2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // MSB index of a field element that holds m trits.
  function automatic int elem_msb(input int m);
    return 2 * m - 1;
  endfunction

  // Sum of two trits mod 3.
  function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    case (s)
      3'd0:    return TRIT_0;
      3'd1:    return TRIT_1;
      3'd2:    return TRIT_2;
      3'd3:    return TRIT_0;
      3'd4:    return TRIT_1;
      default: return TRIT_0;
    endcase
  endfunction

  // Product of two trits mod 3.
  function automatic logic [1:0] trit_mul(input logic [1:0] x, input logic [1:0] y);
    case ({x, y})
      4'b01_01: return TRIT_1;
      4'b01_10: return TRIT_2;
      4'b10_01: return TRIT_2;
      4'b10_10: return TRIT_1;
      default:  return TRIT_0;
    endcase
  endfunction

endpackage

// File: rtl/gf3m_digit_step.sv
// -----------------------------------------------------------------------------
// gf3m_digit_step
// One digit-serial iteration over GF(3^M), f(x) = x^M + x^K + 2:
//   acc_next = acc * x^D + a * digit  (mod f)
// Purely combinational; parametrised by M, K, D (requires D <= K, K+D <= M).
// Ports:
//   acc      in  2*M  running accumulator
//   a        in  2*M  multiplicand
//   digit    in  2*D  D trits of the multiplier, trit 0 has weight x^0
//   acc_next out 2*M  reduced next accumulator
// -----------------------------------------------------------------------------
module gf3m_digit_step
  import gf3m_digit_serial_mult_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int K = K_DEF,
  parameter int D = D_DEF
) (
  input  logic [elem_msb(M):0] acc,
  input  logic [elem_msb(M):0] a,
  input  logic [2*D-1:0]       digit,
  output logic [elem_msb(M):0] acc_next
);

  // Unreduced sum, M+D trits wide: both acc*x^D and a*x^k (k<D) fit below x^(M+D).
  logic [2*(M+D)-1:0] wide_s;

  // Shift, scaled-add, then fold the D overflow trits back into the field.
  always_comb begin
    wide_s = '0;
    wide_s[2*(M+D)-1:2*D] = acc;
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < M; i++) begin
        wide_s[2*(i+k) +: 2] = trit_add(wide_s[2*(i+k) +: 2],
                                        trit_mul(a[2*i +: 2], digit[2*k +: 2]));
      end
    end
    acc_next = wide_s[2*M-1:0];
    // x^(M+j) = 2*x^(K+j) + x^j; K+j < M so a single fold suffices.
    for (int j = 0; j < D; j++) begin
      acc_next[2*j +: 2]     = trit_add(acc_next[2*j +: 2], wide_s[2*(M+j) +: 2]);
      acc_next[2*(K+j) +: 2] = trit_add(acc_next[2*(K+j) +: 2],
                                        trit_mul(TRIT_2, wide_s[2*(M+j) +: 2]));
    end
  end

endmodule

// File: rtl/gf3m_digit_serial_mult.sv
// -----------------------------------------------------------------------------
// gf3m_digit_serial_mult
// Digit-serial multiplier over GF(3^M), f(x) = x^M + x^K + 2. Consumes D trits
// of b per cycle, most significant digit first; latency N+1 cycles, N=ceil(M/D).
// Optional feature macro: GF3M_MULT_ZERO_SKIP_EN -- when defined, a zero
// operand at start bypasses RUN and finishes immediately with c=0; when
// undefined, every operand takes the full constant-time latency.
// Ports:
//   clk    in  1    rising-edge clock
//   reset  in  1    synchronous, active-high
//   start  in  1    request pulse, accepted only in IDLE when done is low
//   a, b   in  2*M  operands, sampled at the accepted start
//   busy   out 1    high from acceptance through the done cycle
//   done   out 1    one-cycle pulse, c valid
//   c      out 2*M  product, held until the next FINISH load or reset
// -----------------------------------------------------------------------------
module gf3m_digit_serial_mult
  import gf3m_digit_serial_mult_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int K = K_DEF,
  parameter int D = D_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [elem_msb(M):0] a,
  input  logic [elem_msb(M):0] b,
  output logic                 busy,
  output logic                 done,
  output logic [elem_msb(M):0] c
);

  localparam int N    = (M + D - 1) / D;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int PADW = 2 * N * D;

  state_t               state_r;
  state_t               state_s;
  logic [elem_msb(M):0] a_r;
  logic [elem_msb(M):0] b_r;
  logic [elem_msb(M):0] acc_r;
  logic [elem_msb(M):0] acc_step_s;
  logic [CW-1:0]        cnt_r;
  logic [PADW-1:0]      b_pad_s;
  logic [2*D-1:0]       digit_s;
  logic                 accept_s;
  logic                 zero_s;

  // Current digit of b; the top digit is zero-padded when D does not divide M.
  always_comb begin
    b_pad_s            = '0;
    b_pad_s[2*M-1:0]   = b_r;
    digit_s            = b_pad_s[2*D*int'(cnt_r) +: 2*D];
  end

  // Zero-operand detection for the optional early-finish path.
  always_comb begin
`ifdef GF3M_MULT_ZERO_SKIP_EN
    zero_s = (a == '0) || (b == '0);
`else
    zero_s = 1'b0;
`endif
  end

  gf3m_digit_step #(.M(M), .K(K), .D(D)) u_step (
    .acc      (acc_r),
    .a        (a_r),
    .digit    (digit_s),
    .acc_next (acc_step_s)
  );

  // Next-state logic; a start seen during the done cycle is ignored.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !done) begin
          accept_s = 1'b1;
          state_s  = zero_s ? FINISH : RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == '0) begin
          state_s = FINISH;
        end else begin
          state_s = RUN;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c       <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= '0;
            cnt_r <= CW'(N - 1);
          end
        end
        RUN: begin
          acc_r <= acc_step_s;
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        FINISH:  c <= acc_r;
        default: ;
      endcase
      done <= (state_r == FINISH);
      // Stays high through the done cycle, which is the cycle after FINISH.
      busy <= (state_s != IDLE) || (state_r == FINISH);
    end
  end

endmodule

// File: tb/tb_gf3m_digit_serial_mult.sv
// -----------------------------------------------------------------------------
// tb_gf3m_digit_serial_mult
// Self-checking bench: table-driven vectors on the default D=4 instance,
// hand-written back-to-back and mid-run reset sequences, and a random sweep
// over D = 1, 3, 4, 12 against a bit-serial reference model.
// -----------------------------------------------------------------------------
module tb_gf3m_digit_serial_mult;

  localparam int M = 97;
  localparam int K = 12;
`ifdef GF3M_MULT_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 26;
`endif

  typedef struct {
    logic [193:0] a;
    logic [193:0] b;
    logic [193:0] c;
    int           lat;
    string        name;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [193:0] a;
  logic [193:0] b;
  logic [3:0]   busy_v;
  logic [3:0]   done_v;
  logic [193:0] c_v [4];

  int           errors;
  int           checks;
  logic [193:0] sb [$];
  int           lat_tab [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gf3m_digit_serial_mult #(.M(M), .K(K), .D(1)) dut_d1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .c(c_v[0]));
  gf3m_digit_serial_mult #(.M(M), .K(K), .D(3)) dut_d3 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .c(c_v[1]));
  gf3m_digit_serial_mult dut_d4 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .c(c_v[2]));
  gf3m_digit_serial_mult #(.M(M), .K(K), .D(12)) dut_d12 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_v[3]), .done(done_v[3]), .c(c_v[3]));

  task automatic check_val(input string name, input logic [193:0] act, input logic [193:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial reference: r = r*x mod f, then r += b_i * a, MSB first.
  function automatic logic [193:0] ref_mul(input logic [193:0] x, input logic [193:0] y);
    int r [M];
    int t;
    logic [193:0] res;
    for (int j = 0; j < M; j++) r[j] = 0;
    for (int i = M - 1; i >= 0; i--) begin
      t = r[M-1];
      for (int j = M - 1; j > 0; j--) r[j] = r[j-1];
      r[0] = t;
      r[K] = (r[K] + 2 * t) % 3;
      for (int j = 0; j < M; j++)
        r[j] = (r[j] + int'(y[2*i +: 2]) * int'(x[2*j +: 2])) % 3;
    end
    res = '0;
    for (int j = 0; j < M; j++) res[2*j +: 2] = 2'(r[j]);
    return res;
  endfunction

  function automatic logic [193:0] rand_elem();
    logic [193:0] v;
    v = '0;
    for (int i = 0; i < M; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  // One operation on the D=4 instance; expected result goes through the scoreboard.
  task automatic run_op(input logic [193:0] ta, input logic [193:0] tb_v,
                        input logic [193:0] exp, input int lat, input string name);
    int cyc;
    a = ta;
    b = tb_v;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done_v[2] !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_int({name, " latency"}, cyc, lat);
    check_int({name, " busy in done cycle"}, int'(busy_v[2]), 1);
    check_val(name, c_v[2], sb.pop_front());
    @(posedge clk); #1;
    check_int({name, " done pulse width"}, int'(done_v[2]), 0);
    check_int({name, " busy after"}, int'(busy_v[2]), 0);
  endtask

  initial begin
    vec_t         tab [8];
    logic [193:0] x96;
    logic [193:0] xp;
    logic [193:0] last_exp;
    logic [193:0] ra;
    logic [193:0] rb;
    logic [193:0] exp;
    int           cyc;
    int           changed;
    int           got [4];
    int           pending;

    errors = 0;
    checks = 0;
    lat_tab = '{98, 34, 26, 10};
    x96 = 194'h1 << 192;
    xp  = 194'haa5a8129a02a0544a4409a500045458901280969815aa820;

    tab[0] = '{194'h1, xp, xp, 26, "identity"};
    tab[1] = '{194'h4, x96, 194'h2000001, 26, "x*x96"};
    tab[2] = '{x96, x96, (194'h1 << 190) | (194'h1 << 44) | (194'h1 << 21), 26, "x96*x96"};
    tab[3] = '{194'h2, 194'h2, 194'h1, 26, "two*two"};
    ra = rand_elem(); rb = rand_elem();
    tab[4] = '{ra, rb, ref_mul(ra, rb), 26, "random0"};
    ra = rand_elem(); rb = rand_elem();
    tab[5] = '{ra, rb, ref_mul(ra, rb), 26, "random1"};
    tab[6] = '{rand_elem(), 194'h0, 194'h0, ZLAT, "b_zero"};
    tab[7] = '{194'h0, rand_elem(), 194'h0, ZLAT, "a_zero"};

    // Sanity of the reference model on the hand-derived products.
    for (int i = 1; i < 4; i++) check_val({"ref ", tab[i].name}, ref_mul(tab[i].a, tab[i].b), tab[i].c);

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check_int("reset busy", int'(busy_v[d]), 0);
      check_int("reset done", int'(done_v[d]), 0);
      check_val("reset c", c_v[d], 194'h0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_op(tab[i].a, tab[i].b, tab[i].c, tab[i].lat, tab[i].name);
    last_exp = tab[7].c;

    // Back-to-back: start held high; operand changes while busy are ignored.
    a = 194'h2;
    b = 194'h2;
    start = 1'b1;
    @(posedge clk); #1;
    a = 194'h4;
    b = x96;
    cyc = 0;
    changed = 0;
    while (done_v[2] !== 1'b1 && cyc < 200) begin
      if (c_v[2] !== last_exp) changed++;
      @(posedge clk); #1;
      cyc++;
    end
    check_int("b2b c held while busy", changed, 0);
    check_int("b2b first latency", cyc, 26);
    check_val("b2b first result", c_v[2], 194'h1);
    @(posedge clk); #1;
    check_int("b2b start ignored in done cycle", int'(busy_v[2]), 0);
    @(posedge clk); #1;
    check_int("b2b accepted in idle", int'(busy_v[2]), 1);
    start = 1'b0;
    cyc = 0;
    while (done_v[2] !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_int("b2b second latency", cyc, 26);
    check_val("b2b second result", c_v[2], 194'h2000001);
    @(posedge clk); #1;

    // Reset at cycle 10 of a run.
    a = rand_elem();
    b = rand_elem();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_int("midrun busy before reset", int'(busy_v[2]), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_int("midrun reset busy", int'(busy_v[2]), 0);
    check_int("midrun reset done", int'(done_v[2]), 0);
    check_val("midrun reset c", c_v[2], 194'h0);
    ra = rand_elem(); rb = rand_elem();
    run_op(ra, rb, ref_mul(ra, rb), 26, "after reset");

    // Sweep over D with a shared start; clear every instance first.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 0; r < 5; r++) begin
      ra = rand_elem();
      rb = rand_elem();
      exp = ref_mul(ra, rb);
      a = ra;
      b = rb;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int d = 0; d < 4; d++) got[d] = -1;
      cyc = 0;
      pending = 4;
      while (pending > 0 && cyc < 150) begin
        @(posedge clk); #1;
        cyc++;
        for (int d = 0; d < 4; d++) begin
          if (got[d] < 0 && done_v[d] === 1'b1) begin
            got[d] = cyc;
            pending--;
            check_val($sformatf("sweep r%0d d%0d product", r, d), c_v[d], exp);
          end
        end
      end
      for (int d = 0; d < 4; d++)
        check_int($sformatf("sweep r%0d d%0d latency", r, d), got[d], lat_tab[d]);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
